csr_unit: RTL and testbench

- Machine/supervisor CSR file and privilege controller for the RV32 pipeline; the consumer of the decode-stage CSR outputs (csr_op, csr_addr, priv_ret).
- Sits at the EX/MEM boundary.
- Executes csrrw/csrrs, mret/sret and synchronous exceptions.
- Holds the current privilege mode and issues a registered PC redirect plus pipeline flush for traps and returns.

---
 rtl/csr_pkg.sv | 71 +++++++
 rtl/csr_counter64.sv | 25 ++
 rtl/csr_unit.sv | 183 ++++++++++++++++++
 tb/tb_csr_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared constants, encodings and helpers for the machine/supervisor CSR unit
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_STVEC    = 12'h105;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;
  localparam logic [11:0] CSR_SEPC     = 12'h141;
  localparam logic [11:0] CSR_SCAUSE   = 12'h142;
  localparam logic [11:0] CSR_STVAL    = 12'h143;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mcause codes
  localparam logic [3:0] CAUSE_ILLEGAL_INSN = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_U      = 4'd8;
  localparam logic [3:0] CAUSE_ECALL_S      = 4'd9;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  // privilege encodings
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RSVD = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    RET_NONE = 2'b00,
    RET_MRET = 2'b01,
    RET_SRET = 2'b10,
    RET_RSVD = 2'b11
  } priv_ret_e;

  // mstatus bit positions
  localparam int MSTATUS_SIE    = 1;
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_SPIE   = 5;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_SPP    = 8;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_MASK = 32'h0000_19AA;
  localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;
  localparam logic [31:0] MISA_VALUE   = 32'h4014_0100;

  // Drop unimplemented bits and map the reserved MPP encoding 10 onto U
  function automatic logic [31:0] mstatus_legalize(input logic [31:0] value);
    logic [31:0] v;
    v = value & MSTATUS_MASK;
    if (v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == 2'b10) v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit free-running counter with per-half software writes
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // A write to either half suppresses the increment for the whole counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 64'd0;
    end else if (wr_lo) begin
      count[31:0] <= wdata;
    end else if (wr_hi) begin
      count[63:32] <= wdata;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine/supervisor CSR file and privilege controller at EX/MEM
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [1:0]      priv_ret,
  input  logic [XLEN-1:0] pc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [1:0]      priv_mode
);

  csr_op_e   op;
  priv_ret_e ret;
  assign op  = csr_op_e'(csr_op);
  assign ret = priv_ret_e'(priv_ret);

  logic [31:0] mstatus, mtvec, mscratch, mepc, mcause, mtval;
  logic [31:0] stvec, sscratch, sepc, scause, stval;
  logic [63:0] mcycle, minstret;

  logic        implemented;
  logic        csr_access;
  logic        access_bad;
  logic        ret_bad;
  logic        live;
  logic        take_trap, take_mret, take_sret, take_write;
  logic [31:0] wval;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  // Read mux: old value of the addressed CSR, zero for unimplemented addresses
  always_comb begin
    implemented = 1'b1;
    csr_rdata   = 32'd0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus;
      CSR_MISA:      csr_rdata = MISA_VALUE;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MTVAL:     csr_rdata = mtval;
      CSR_SSTATUS:   csr_rdata = mstatus & SSTATUS_MASK;
      CSR_STVEC:     csr_rdata = stvec;
      CSR_SSCRATCH:  csr_rdata = sscratch;
      CSR_SEPC:      csr_rdata = sepc;
      CSR_SCAUSE:    csr_rdata = scause;
      CSR_STVAL:     csr_rdata = stval;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MHARTID:   csr_rdata = HART_ID;
      default:       implemented = 1'b0;
    endcase
  end

  // Legality and event selection; a pending redirect blocks every event
  always_comb begin
    csr_access  = (op == CSR_OP_RW) || (op == CSR_OP_RS);
    access_bad  = csr_access && (!implemented || (csr_addr[9:8] > priv_mode) ||
                                 ((op == CSR_OP_RW) && (csr_addr[11:10] == 2'b11)));
    ret_bad     = ((ret == RET_MRET) && (priv_mode != PRIV_M)) ||
                  ((ret == RET_SRET) && (priv_mode == PRIV_U));
    csr_illegal = valid && (access_bad || ret_bad);
    live        = valid && !redirect_valid;
    take_trap   = live && (exc_valid || csr_illegal);
    take_mret   = live && !take_trap && (ret == RET_MRET);
    take_sret   = live && !take_trap && (ret == RET_SRET);
    take_write  = live && !take_trap && (ret != RET_MRET) && (ret != RET_SRET) &&
                  csr_access && (csr_addr[11:10] != 2'b11);
    wval        = (op == CSR_OP_RW) ? csr_wdata : (csr_rdata | csr_wdata);
    trap_cause  = {28'd0, exc_valid ? exc_cause : CAUSE_ILLEGAL_INSN};
    trap_tval   = exc_valid ? exc_tval : 32'd0;
  end

  assign cyc_wr_lo = take_write && (csr_addr == CSR_MCYCLE);
  assign cyc_wr_hi = take_write && (csr_addr == CSR_MCYCLEH);
  assign ins_wr_lo = take_write && (csr_addr == CSR_MINSTRET);
  assign ins_wr_hi = take_write && (csr_addr == CSR_MINSTRETH);

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (wval),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (retire),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (wval),
    .count (minstret)
  );

  // Apply the single selected event and launch the one-cycle redirect pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_mode      <= PRIV_M;
      mstatus        <= 32'd0;
      mtvec          <= MTVEC_RST & ~32'h3;
      mscratch       <= 32'd0;
      mepc           <= 32'd0;
      mcause         <= 32'd0;
      mtval          <= 32'd0;
      stvec          <= 32'd0;
      sscratch       <= 32'd0;
      sepc           <= 32'd0;
      scause         <= 32'd0;
      stval          <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= 1'b0;
      if (take_trap) begin
        mepc                                  <= pc & ~32'h3;
        mcause                                <= trap_cause;
        mtval                                 <= trap_tval;
        mstatus[MSTATUS_MPIE]                 <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]                  <= 1'b0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= priv_mode;
        priv_mode                             <= PRIV_M;
        redirect_valid                        <= 1'b1;
        redirect_pc                           <= mtvec & ~32'h3;
      end else if (take_mret) begin
        priv_mode                             <= mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
        mstatus[MSTATUS_MIE]                  <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE]                 <= 1'b1;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= PRIV_U;
        redirect_valid                        <= 1'b1;
        redirect_pc                           <= mepc;
      end else if (take_sret) begin
        priv_mode             <= {1'b0, mstatus[MSTATUS_SPP]};
        mstatus[MSTATUS_SIE]  <= mstatus[MSTATUS_SPIE];
        mstatus[MSTATUS_SPIE] <= 1'b1;
        mstatus[MSTATUS_SPP]  <= 1'b0;
        redirect_valid        <= 1'b1;
        redirect_pc           <= sepc;
      end else if (take_write) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus  <= mstatus_legalize(wval);
          CSR_SSTATUS:  mstatus  <= mstatus_legalize((mstatus & ~SSTATUS_MASK) |
                                                     (wval & SSTATUS_MASK));
          CSR_MTVEC:    mtvec    <= wval;
          CSR_MSCRATCH: mscratch <= wval;
          CSR_MEPC:     mepc     <= wval & ~32'h3;
          CSR_MCAUSE:   mcause   <= wval;
          CSR_MTVAL:    mtval    <= wval;
          CSR_STVEC:    stvec    <= wval;
          CSR_SSCRATCH: sscratch <= wval;
          CSR_SEPC:     sepc     <= wval & ~32'h3;
          CSR_SCAUSE:   scause   <= wval;
          CSR_STVAL:    stval    <= wval;
          default:      ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit with a field-level reference model
module tb_csr_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] HART_ID   = 32'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = 32'd0;
  logic [1:0]  priv_ret = 2'b00;
  logic [31:0] pc = 32'd0;
  logic        exc_valid = 1'b0;
  logic [3:0]  exc_cause = 4'd0;
  logic [31:0] exc_tval = 32'd0;
  logic        retire = 1'b0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  priv_mode;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
    .clk(clk), .rst(rst), .valid(valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .priv_ret(priv_ret), .pc(pc), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_tval(exc_tval), .retire(retire), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .priv_mode(priv_mode)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: mstatus as separate fields, plain registers in a table
  logic [1:0]  m_priv;
  bit          m_mie, m_sie, m_mpie, m_spie, m_spp;
  logic [1:0]  m_mpp;
  logic [31:0] m_reg [int];
  logic [63:0] m_cyc, m_ins;
  bit          m_rv;
  logic [31:0] m_rpc;
  bit          w_cyc, w_ins;

  logic [31:0] obs_rdata, obs_rpc;
  logic        obs_ill, obs_rv;
  logic [1:0]  obs_priv;

  int addr_pool [22] = '{'h300, 'h301, 'h305, 'h340, 'h341, 'h342, 'h343, 'h100, 'h105,
                         'h140, 'h141, 'h142, 'h143, 'hB00, 'hB80, 'hB02, 'hB82, 'hF14,
                         'h7C0, 'h344, 'hC00, 'h180};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_priv = 2'b11;
    {m_mie, m_sie, m_mpie, m_spie, m_spp} = '0;
    m_mpp = 2'b00;
    m_reg.delete();
    m_reg['h305] = MTVEC_RST & ~32'h3;
    foreach (addr_pool[i]) if (addr_pool[i] inside {'h340, 'h341, 'h342, 'h343, 'h105, 'h140,
                                                     'h141, 'h142, 'h143}) m_reg[addr_pool[i]] = 32'd0;
    m_cyc = 64'd0;
    m_ins = 64'd0;
    m_rv  = 1'b0;
    m_rpc = 32'd0;
  endtask

  function automatic logic [31:0] m_mstatus();
    logic [31:0] v = 32'd0;
    v[1] = m_sie; v[3] = m_mie; v[5] = m_spie; v[7] = m_mpie; v[8] = m_spp; v[12:11] = m_mpp;
    return v;
  endfunction

  function automatic bit m_impl(input logic [11:0] a);
    if (int'(a) inside {'h300, 'h301, 'h100, 'hB00, 'hB80, 'hB02, 'hB82, 'hF14}) return 1'b1;
    return m_reg.exists(int'(a));
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (int'(a))
      'h300:   return m_mstatus();
      'h100:   return m_mstatus() & 32'h122;
      'h301:   return 32'h4014_0100;
      'hB00:   return m_cyc[31:0];
      'hB80:   return m_cyc[63:32];
      'hB02:   return m_ins[31:0];
      'hB82:   return m_ins[63:32];
      'hF14:   return HART_ID;
      default: return m_reg.exists(int'(a)) ? m_reg[int'(a)] : 32'd0;
    endcase
  endfunction

  function automatic bit m_illegal(input logic [1:0] op, input logic [11:0] a, input logic [1:0] r);
    bit bad = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      if (!m_impl(a)) bad = 1'b1;
      if (a[9:8] > m_priv) bad = 1'b1;
      if (op == 2'd1 && a[11:10] == 2'b11) bad = 1'b1;
    end
    if (r == 2'd1 && m_priv != 2'b11) bad = 1'b1;
    if (r == 2'd2 && m_priv == 2'b00) bad = 1'b1;
    return bad;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (int'(a))
      'h300: begin
        m_sie = v[1]; m_mie = v[3]; m_spie = v[5]; m_mpie = v[7]; m_spp = v[8];
        m_mpp = (v[12:11] == 2'b10) ? 2'b00 : v[12:11];
      end
      'h100: begin m_sie = v[1]; m_spie = v[5]; m_spp = v[8]; end
      'hB00: begin m_cyc[31:0]  = v; w_cyc = 1'b1; end
      'hB80: begin m_cyc[63:32] = v; w_cyc = 1'b1; end
      'hB02: begin m_ins[31:0]  = v; w_ins = 1'b1; end
      'hB82: begin m_ins[63:32] = v; w_ins = 1'b1; end
      'h341, 'h141: m_reg[int'(a)] = v & ~32'h3;
      default: if (m_reg.exists(int'(a))) m_reg[int'(a)] = v;
    endcase
  endtask

  task automatic m_step(input bit v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input logic [1:0] r, input logic [31:0] pcv, input bit exc,
                        input logic [3:0] cause, input logic [31:0] tval, input bit ret_i);
    bit nrv = 1'b0;
    bit ill;
    w_cyc = 1'b0;
    w_ins = 1'b0;
    if (v && !m_rv) begin
      ill = m_illegal(op, a, r);
      if (exc || ill) begin
        m_reg['h341] = pcv & ~32'h3;
        m_reg['h342] = exc ? {28'd0, cause} : 32'd2;
        m_reg['h343] = exc ? tval : 32'd0;
        m_mpie = m_mie; m_mie = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
        nrv = 1'b1; m_rpc = m_reg['h305] & ~32'h3;
      end else if (r == 2'd1) begin
        m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
        nrv = 1'b1; m_rpc = m_reg['h341];
      end else if (r == 2'd2) begin
        m_priv = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1'b1; m_spp = 1'b0;
        nrv = 1'b1; m_rpc = m_reg['h141];
      end else if ((op == 2'd1 || op == 2'd2) && a[11:10] != 2'b11) begin
        m_write(a, (op == 2'd1) ? wd : (m_read(a) | wd));
      end
    end
    if (!w_cyc) m_cyc = m_cyc + 64'd1;
    if (!w_ins && ret_i) m_ins = m_ins + 64'd1;
    m_rv = nrv;
  endtask

  // one clock: drive after the falling edge, check before the rising edge, end on the next falling edge
  task automatic do_cycle(input bit v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                          input logic [1:0] r, input logic [31:0] pcv, input bit exc,
                          input logic [3:0] cause, input logic [31:0] tval, input bit ret_i);
    valid = v; csr_op = op; csr_addr = a; csr_wdata = wd; priv_ret = r; pc = pcv;
    exc_valid = exc; exc_cause = cause; exc_tval = tval; retire = ret_i;
    #1;
    obs_rdata = csr_rdata; obs_ill = csr_illegal; obs_priv = priv_mode;
    obs_rv = redirect_valid; obs_rpc = redirect_pc;
    check("rdata", csr_rdata, m_read(a));
    check("illegal", {31'd0, csr_illegal}, {31'd0, v && m_illegal(op, a, r)});
    check("priv_mode", {30'd0, priv_mode}, {30'd0, m_priv});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
    check("redirect_pc", redirect_pc, m_rpc);
    m_step(v, op, a, wd, r, pcv, exc, cause, tval, ret_i);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a);
    do_cycle(1'b0, 2'd0, a, 32'd0, 2'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic csrw(input logic [11:0] a, input logic [31:0] v);
    do_cycle(1'b1, 2'd1, a, v, 2'd0, 32'h1000, 1'b0, 4'd0, 32'd0, 1'b1);
  endtask

  task automatic csrs(input logic [11:0] a, input logic [31:0] v);
    do_cycle(1'b1, 2'd2, a, v, 2'd0, 32'h1004, 1'b0, 4'd0, 32'd0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0; csr_op = 2'd0; csr_addr = 12'h305; csr_wdata = 32'd0; priv_ret = 2'd0;
    pc = 32'd0; exc_valid = 1'b0; exc_cause = 4'd0; exc_tval = 32'd0; retire = 1'b0;
    #1;
    check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_priv", {30'd0, priv_mode}, 32'd3);
    check("rst_mtvec", csr_rdata, 32'h0000_1000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();

    // scratch write returns old value, read-back returns new
    csrw(12'h340, 32'hDEAD_BEEF);
    check("mscratch_old", obs_rdata, 32'd0);
    rd(12'h340);
    check("mscratch_new", obs_rdata, 32'hDEAD_BEEF);

    // ecall-M style exception from M with MIE set
    csrw(12'h305, 32'h100);
    csrw(12'h300, 32'h8);
    do_cycle(1'b1, 2'd0, 12'h000, 32'd0, 2'd0, 32'h80, 1'b1, 4'd11, 32'h55, 1'b1);
    rd(12'h341);
    check("trap_rv", {31'd0, obs_rv}, 32'd1);
    check("trap_rpc", obs_rpc, 32'h100);
    check("trap_mepc", obs_rdata, 32'h80);
    rd(12'h342);
    check("trap_mcause", obs_rdata, 32'd11);
    check("trap_rv_one_cycle", {31'd0, obs_rv}, 32'd0);
    rd(12'h300);
    check("trap_mstatus", obs_rdata, 32'h0000_1880);

    // mret into U, then a privileged access traps back to M
    csrw(12'h300, 32'h0);
    csrw(12'h341, 32'h200);
    do_cycle(1'b1, 2'd0, 12'h000, 32'd0, 2'd1, 32'h90, 1'b0, 4'd0, 32'd0, 1'b1);
    rd(12'h300);
    check("mret_rv", {31'd0, obs_rv}, 32'd1);
    check("mret_rpc", obs_rpc, 32'h200);
    check("mret_priv", {30'd0, obs_priv}, 32'd0);
    csrs(12'h300, 32'h0);
    check("u_access_illegal", {31'd0, obs_ill}, 32'd1);
    rd(12'h342);
    check("u_trap_priv", {30'd0, obs_priv}, 32'd3);
    check("u_trap_cause", obs_rdata, 32'd2);

    // read-only mhartid: csrrw traps, csrrs with zero reads it
    csrw(12'hF14, 32'h123);
    check("hartid_rw_illegal", {31'd0, obs_ill}, 32'd1);
    rd(12'h342);
    check("hartid_rw_rv", {31'd0, obs_rv}, 32'd1);
    csrs(12'hF14, 32'h0);
    check("hartid_value", obs_rdata, 32'd5);
    check("hartid_rs_legal", {31'd0, obs_ill}, 32'd0);
    rd(12'h000);
    check("hartid_rs_no_trap", {31'd0, obs_rv}, 32'd0);

    // 64-bit wrap of mcycle
    csrw(12'hB00, 32'hFFFF_FFFF);
    csrw(12'hB80, 32'hFFFF_FFFF);
    rd(12'hB00);
    check("mcycle_max_lo", obs_rdata, 32'hFFFF_FFFF);
    rd(12'hB00);
    check("mcycle_wrap_lo", obs_rdata, 32'd0);
    rd(12'hB80);
    check("mcycle_wrap_hi", obs_rdata, 32'd0);

    // exception wins over a simultaneous mret; mtvec low bits ignored
    csrw(12'h305, 32'h203);
    do_cycle(1'b1, 2'd0, 12'h000, 32'd0, 2'd1, 32'h300, 1'b1, 4'd3, 32'h77, 1'b0);
    rd(12'h342);
    check("prio_rpc", obs_rpc, 32'h200);
    check("prio_cause", obs_rdata, 32'd3);
    check("prio_priv", {30'd0, obs_priv}, 32'd3);

    // reset while a redirect is pending
    do_cycle(1'b1, 2'd0, 12'h000, 32'd0, 2'd0, 32'h400, 1'b1, 4'd8, 32'h0, 1'b0);
    #1;
    check("pre_reset_rv", {31'd0, redirect_valid}, 32'd1);
    do_reset();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0]  r_op, r_ret;
      logic [11:0] r_addr;
      bit          r_valid, r_exc;
      r_valid = ($urandom_range(0, 7) != 0);
      r_op    = 2'($urandom_range(0, 3));
      r_addr  = 12'(addr_pool[$urandom_range(0, 21)]);
      r_ret   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      r_exc   = ($urandom_range(0, 15) == 0);
      do_cycle(r_valid, r_op, r_addr, $urandom, r_ret, $urandom, r_exc,
               4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
